// File: rtl/rx_seq_checker.sv
// Sequence-ID continuity checker for the voted frame byte stream, with saturating statistics.
// Define RX_SEQ_CHECKER_FCS_EN to add CRC-32 FCS checking of each frame.
module rx_seq_checker #(
    parameter logic [5:0] ID_OFFSET = 6'h22,
    parameter int         CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_in,
    input  logic [7:0]       data_in,
    input  logic             loss_in,
    input  logic             clear_stats,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] gap_cnt,
    output logic [CNT_W-1:0] stale_cnt,
    output logic [CNT_W-1:0] runt_cnt,
    output logic [CNT_W-1:0] loss_cnt,
    output logic [CNT_W-1:0] fcs_err_cnt,
    output logic [15:0]      last_id,
    output logic             synced,
    output logic             frame_done,
    output logic             seq_err
);

    localparam logic [2:0] S_WAIT_IDLE = 3'd0;
    localparam logic [2:0] S_IDLE      = 3'd1;
    localparam logic [2:0] S_HDR       = 3'd2;
    localparam logic [2:0] S_ID_HI     = 3'd3;
    localparam logic [2:0] S_ID_LO     = 3'd4;
    localparam logic [2:0] S_PAYLOAD   = 3'd5;
    localparam logic [2:0] S_EVAL      = 3'd6;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [2:0]       state_q, state_d;
    logic [5:0]       byte_cnt_q, byte_cnt_d;
    logic [15:0]      id_q, id_d;
    logic             runt_q, runt_d;
    logic [15:0]      expected_id_q, expected_id_d;
    logic [15:0]      last_id_q, last_id_d;
    logic             synced_q, synced_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0] stale_cnt_q, stale_cnt_d;
    logic [CNT_W-1:0] runt_cnt_q, runt_cnt_d;
    logic [CNT_W-1:0] loss_cnt_q, loss_cnt_d;
    logic             loss_prev_q, loss_prev_d;
    logic             frame_done_q, frame_done_d;
    logic             seq_err_q, seq_err_d;
    logic             start_frame;
    logic [15:0]      delta;
    logic [CNT_W:0]   gap_sum;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

`ifdef RX_SEQ_CHECKER_FCS_EN
    // Reflected-register form of the 0xC704DD7B good-frame residue.
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    logic [31:0]      crc_q, crc_d;
    logic [CNT_W-1:0] fcs_err_cnt_q, fcs_err_cnt_d;

    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc ^ {24'd0, b};
        for (int i = 0; i < 8; i++)
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction
`endif

    always_comb begin
        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        id_d          = id_q;
        runt_d        = runt_q;
        expected_id_d = expected_id_q;
        last_id_d     = last_id_q;
        synced_d      = synced_q;
        frame_cnt_d   = frame_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        stale_cnt_d   = stale_cnt_q;
        runt_cnt_d    = runt_cnt_q;
        loss_cnt_d    = loss_cnt_q;
        loss_prev_d   = loss_in;
        frame_done_d  = 1'b0;
        seq_err_d     = 1'b0;
        start_frame   = 1'b0;
        delta         = id_q - expected_id_q;
        gap_sum       = {1'b0, gap_cnt_q} + (CNT_W+1)'(delta);
`ifdef RX_SEQ_CHECKER_FCS_EN
        crc_d         = crc_q;
        fcs_err_cnt_d = fcs_err_cnt_q;
        if (en_in && (state_q inside {S_HDR, S_ID_HI, S_ID_LO, S_PAYLOAD}))
            crc_d = crc_byte(crc_q, data_in);
`endif

        case (state_q)
            S_WAIT_IDLE: if (!en_in) state_d = S_IDLE;
            S_IDLE:      start_frame = en_in;
            S_HDR: begin
                if (!en_in) begin
                    state_d = S_EVAL;
                    runt_d  = 1'b1;
                end else begin
                    byte_cnt_d = byte_cnt_q + 6'd1;
                    if (byte_cnt_d == ID_OFFSET) state_d = S_ID_HI;
                end
            end
            S_ID_HI: begin
                if (!en_in) begin
                    state_d = S_EVAL;
                    runt_d  = 1'b1;
                end else begin
                    id_d[15:8] = data_in;
                    state_d    = S_ID_LO;
                end
            end
            S_ID_LO: begin
                if (!en_in) begin
                    state_d = S_EVAL;
                    runt_d  = 1'b1;
                end else begin
                    id_d[7:0] = data_in;
                    state_d   = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (!en_in) begin
                    state_d = S_EVAL;
                    runt_d  = 1'b0;
                end
            end
            S_EVAL: begin
                frame_done_d = 1'b1;
                if (runt_q) begin
                    runt_cnt_d = sat_inc(runt_cnt_q);
`ifdef RX_SEQ_CHECKER_FCS_EN
                end else if (crc_q != CRC_RESIDUE) begin
                    fcs_err_cnt_d = sat_inc(fcs_err_cnt_q);
                    seq_err_d     = 1'b1;
`endif
                end else if (synced_q && delta[15]) begin
                    stale_cnt_d = sat_inc(stale_cnt_q);
                    seq_err_d   = 1'b1;
                end else begin
                    frame_cnt_d   = sat_inc(frame_cnt_q);
                    last_id_d     = id_q;
                    expected_id_d = id_q + 16'd1;
                    synced_d      = 1'b1;
                    if (synced_q && delta != 16'd0) begin
                        gap_cnt_d = gap_sum[CNT_W] ? '1 : gap_sum[CNT_W-1:0];
                        seq_err_d = 1'b1;
                    end
                end
                // A new frame may start in the same cycle the previous one is evaluated.
                if (en_in) start_frame = 1'b1;
                else       state_d     = S_IDLE;
            end
            default: state_d = S_WAIT_IDLE;
        endcase

        if (start_frame) begin
            byte_cnt_d = 6'd1;
            state_d    = (ID_OFFSET == 6'd1) ? S_ID_HI : S_HDR;
`ifdef RX_SEQ_CHECKER_FCS_EN
            crc_d      = crc_byte(32'hFFFFFFFF, data_in);
`endif
        end

        if (loss_in && !loss_prev_q) loss_cnt_d = sat_inc(loss_cnt_q);

        if (clear_stats) begin
            state_d       = S_WAIT_IDLE;
            expected_id_d = '0;
            last_id_d     = '0;
            synced_d      = 1'b0;
            frame_cnt_d   = '0;
            gap_cnt_d     = '0;
            stale_cnt_d   = '0;
            runt_cnt_d    = '0;
            loss_cnt_d    = '0;
            frame_done_d  = 1'b0;
            seq_err_d     = 1'b0;
`ifdef RX_SEQ_CHECKER_FCS_EN
            fcs_err_cnt_d = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_WAIT_IDLE;
            byte_cnt_q    <= '0;
            id_q          <= '0;
            runt_q        <= 1'b0;
            expected_id_q <= '0;
            last_id_q     <= '0;
            synced_q      <= 1'b0;
            frame_cnt_q   <= '0;
            gap_cnt_q     <= '0;
            stale_cnt_q   <= '0;
            runt_cnt_q    <= '0;
            loss_cnt_q    <= '0;
            loss_prev_q   <= 1'b0;
            frame_done_q  <= 1'b0;
            seq_err_q     <= 1'b0;
`ifdef RX_SEQ_CHECKER_FCS_EN
            crc_q         <= 32'hFFFFFFFF;
            fcs_err_cnt_q <= '0;
`endif
        end else begin
            state_q       <= state_d;
            byte_cnt_q    <= byte_cnt_d;
            id_q          <= id_d;
            runt_q        <= runt_d;
            expected_id_q <= expected_id_d;
            last_id_q     <= last_id_d;
            synced_q      <= synced_d;
            frame_cnt_q   <= frame_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            stale_cnt_q   <= stale_cnt_d;
            runt_cnt_q    <= runt_cnt_d;
            loss_cnt_q    <= loss_cnt_d;
            loss_prev_q   <= loss_prev_d;
            frame_done_q  <= frame_done_d;
            seq_err_q     <= seq_err_d;
`ifdef RX_SEQ_CHECKER_FCS_EN
            crc_q         <= crc_d;
            fcs_err_cnt_q <= fcs_err_cnt_d;
`endif
        end
    end

    assign frame_cnt  = frame_cnt_q;
    assign gap_cnt    = gap_cnt_q;
    assign stale_cnt  = stale_cnt_q;
    assign runt_cnt   = runt_cnt_q;
    assign loss_cnt   = loss_cnt_q;
    assign last_id    = last_id_q;
    assign synced     = synced_q;
    assign frame_done = frame_done_q;
    assign seq_err    = seq_err_q;
`ifdef RX_SEQ_CHECKER_FCS_EN
    assign fcs_err_cnt = fcs_err_cnt_q;
`else
    assign fcs_err_cnt = '0;
`endif

endmodule

// File: tb/tb_rx_seq_checker.sv
// Bench for rx_seq_checker: directed vector table, hand-written corner sequences,
// and randomized frames checked against a frame-level reference model.
module tb_rx_seq_checker;

    logic        clk = 1'b0;
    logic        reset, en_in, loss_in, clear_stats;
    logic [7:0]  data_in;
    logic [31:0] frame_cnt, gap_cnt, stale_cnt, runt_cnt, loss_cnt, fcs_err_cnt;
    logic [15:0] last_id;
    logic        synced, frame_done, seq_err;

    rx_seq_checker dut (
        .clk(clk), .reset(reset), .en_in(en_in), .data_in(data_in), .loss_in(loss_in),
        .clear_stats(clear_stats), .frame_cnt(frame_cnt), .gap_cnt(gap_cnt),
        .stale_cnt(stale_cnt), .runt_cnt(runt_cnt), .loss_cnt(loss_cnt),
        .fcs_err_cnt(fcs_err_cnt), .last_id(last_id), .synced(synced),
        .frame_done(frame_done), .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc ^ {24'd0, b};
        for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    // Frame-level reference model: ID continuity rules applied with plain integer arithmetic.
    typedef struct {
        int     cyc;
        bit     se;
        longint fc, gc, sc, rc;
        int     last;
        bit     syn;
    } ev_t;
    ev_t    evq[$];
    bit     mon_en = 0;
    bit     m_syn;
    int     m_exp, m_last;
    longint m_fc, m_gc, m_sc, m_rc;

    task automatic model_reset();
        m_syn = 0; m_exp = 0; m_last = 0;
        m_fc = 0; m_gc = 0; m_sc = 0; m_rc = 0;
    endtask

    task automatic model_frame(input int id, input int len, input bit corrupt, input int ecyc);
        ev_t e;
        bit  bad_fcs;
        int  d;
        bad_fcs = 0;
`ifdef RX_SEQ_CHECKER_FCS_EN
        bad_fcs = corrupt;
`endif
        e.se = 0;
        if (len < 36) m_rc++;
        else if (bad_fcs) e.se = 1;
        else begin
            d = (id - m_exp + 65536) % 65536;
            if (m_syn && d >= 32768) begin
                m_sc++;
                e.se = 1;
            end else begin
                if (m_syn && d != 0) begin
                    m_gc += d;
                    e.se = 1;
                end
                m_fc++;
                m_syn  = 1;
                m_last = id;
                m_exp  = (id + 1) % 65536;
            end
        end
        e.cyc = ecyc; e.fc = m_fc; e.gc = m_gc; e.sc = m_sc; e.rc = m_rc;
        e.last = m_last; e.syn = m_syn;
        evq.push_back(e);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (evq.size() > 0 && evq[0].cyc < cyc) begin
                chk("mon_missed_event", 1, 0);
                void'(evq.pop_front());
            end else if (evq.size() > 0 && evq[0].cyc == cyc) begin
                ev_t e;
                e = evq.pop_front();
                chk("mon_frame_done", frame_done, 1);
                chk("mon_seq_err", seq_err, e.se);
                chk("mon_frame_cnt", frame_cnt, e.fc);
                chk("mon_gap_cnt", gap_cnt, e.gc);
                chk("mon_stale_cnt", stale_cnt, e.sc);
                chk("mon_runt_cnt", runt_cnt, e.rc);
                chk("mon_last_id", last_id, e.last);
                chk("mon_synced", synced, e.syn);
            end else begin
                chk("mon_frame_done_idle", frame_done, 0);
            end
        end
    end

    logic fd1, fd2, se2;

    task automatic send_frame(input int id, input int len, input bit corrupt, input int gap);
        logic [7:0]  b [0:127];
        logic [31:0] c;
        for (int i = 0; i < len; i++) b[i] = 8'($urandom_range(0, 255));
        if (len > 35) begin
            b[34] = id[15:8];
            b[35] = id[7:0];
        end
        if (len >= 40) begin
            c = 32'hFFFFFFFF;
            for (int i = 0; i < len - 4; i++) c = crc_upd(c, b[i]);
            c = ~c;
            for (int k = 0; k < 4; k++) b[len-4+k] = c[8*k +: 8];
        end
        if (corrupt) b[20] = b[20] ^ 8'h5A;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            en_in = 1'b1; data_in = b[i];
        end
        @(negedge clk);
        en_in = 1'b0; data_in = 8'h00;
        if (mon_en) model_frame(id, len, corrupt, cyc + 2);
        fd1 = 0; fd2 = 0; se2 = 0;
        for (int k = 1; k <= gap; k++) begin
            @(negedge clk);
            if (k == 1) fd1 = frame_done;
            if (k == 2) begin
                fd2 = frame_done;
                se2 = seq_err;
            end
        end
    endtask

    task automatic do_clear();
        @(negedge clk); clear_stats = 1'b1;
        @(negedge clk); clear_stats = 1'b0;
        chk("clr_frame_cnt", frame_cnt, 0);
        chk("clr_synced", synced, 0);
    endtask

    typedef struct {
        bit clr;
        int id, len;
        bit se;
        int fc, gc, sc, rc, last;
        bit syn;
    } vec_t;
    vec_t tbl[$];

    initial begin
        logic fd_any;
        int   lcnt, id, len, r;
        bit   prev, v;

        reset = 1'b1; en_in = 1'b0; data_in = 8'h00; loss_in = 1'b0; clear_stats = 1'b0;

        //        clr id       len se fc gc sc rc last     syn
        tbl.push_back('{1, 0,       64, 0, 1, 0, 0, 0, 0,       1});
        tbl.push_back('{0, 1,       64, 0, 2, 0, 0, 0, 1,       1});
        tbl.push_back('{0, 2,       64, 0, 3, 0, 0, 0, 2,       1});
        tbl.push_back('{1, 5,       64, 0, 1, 0, 0, 0, 5,       1});
        tbl.push_back('{0, 6,       64, 0, 2, 0, 0, 0, 6,       1});
        tbl.push_back('{0, 9,       64, 1, 3, 2, 0, 0, 9,       1});
        tbl.push_back('{1, 'hFFFE,  64, 0, 1, 0, 0, 0, 'hFFFE,  1});
        tbl.push_back('{0, 'hFFFF,  64, 0, 2, 0, 0, 0, 'hFFFF,  1});
        tbl.push_back('{0, 0,       64, 0, 3, 0, 0, 0, 0,       1});
        tbl.push_back('{1, 10,      64, 0, 1, 0, 0, 0, 10,      1});
        tbl.push_back('{0, 11,      64, 0, 2, 0, 0, 0, 11,      1});
        tbl.push_back('{0, 11,      64, 1, 2, 0, 1, 0, 11,      1});
        tbl.push_back('{0, 7,       64, 1, 2, 0, 2, 0, 11,      1});
        tbl.push_back('{1, 3,       35, 0, 0, 0, 0, 1, 0,       0});
        tbl.push_back('{0, 3,       10, 0, 0, 0, 0, 2, 0,       0});
        tbl.push_back('{0, 3,       40, 0, 1, 0, 0, 2, 3,       1});
        tbl.push_back('{0, 4,       40, 0, 2, 0, 0, 2, 4,       1});
        tbl.push_back('{0, 99,      20, 0, 2, 0, 0, 3, 4,       1});

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_gap_cnt", gap_cnt, 0);
        chk("rst_stale_cnt", stale_cnt, 0);
        chk("rst_runt_cnt", runt_cnt, 0);
        chk("rst_loss_cnt", loss_cnt, 0);
        chk("rst_fcs_err_cnt", fcs_err_cnt, 0);
        chk("rst_last_id", last_id, 0);
        chk("rst_synced", synced, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_seq_err", seq_err, 0);

        foreach (tbl[i]) begin
            if (tbl[i].clr) do_clear();
            send_frame(tbl[i].id, tbl[i].len, 1'b0, 3);
            chk("tbl_done_early", fd1, 0);
            chk("tbl_frame_done", fd2, 1);
            chk("tbl_seq_err", se2, tbl[i].se);
            chk("tbl_frame_cnt", frame_cnt, tbl[i].fc);
            chk("tbl_gap_cnt", gap_cnt, tbl[i].gc);
            chk("tbl_stale_cnt", stale_cnt, tbl[i].sc);
            chk("tbl_runt_cnt", runt_cnt, tbl[i].rc);
            chk("tbl_last_id", last_id, tbl[i].last);
            chk("tbl_synced", synced, tbl[i].syn);
        end

        // Clear in the evaluation cycle drops that frame entirely.
        do_clear();
        send_frame(1, 64, 1'b0, 3);
        chk("ceval_pre_cnt", frame_cnt, 1);
        send_frame(2, 64, 1'b0, 0);
        @(negedge clk); clear_stats = 1'b1;
        @(negedge clk); clear_stats = 1'b0;
        chk("ceval_frame_done", frame_done, 0);
        chk("ceval_frame_cnt", frame_cnt, 0);
        chk("ceval_last_id", last_id, 0);
        send_frame(9, 64, 1'b0, 3);
        chk("ceval_next_cnt", frame_cnt, 1);
        chk("ceval_next_last", last_id, 9);
        chk("ceval_next_se", se2, 0);

        // Reset in the middle of a frame with en_in held high.
        send_frame(40, 64, 1'b0, 3);
        fd_any = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            fd_any |= frame_done;
            en_in = 1'b1; data_in = 8'($urandom_range(0, 255));
            if (i == 20) reset = 1'b1;
            if (i == 22) reset = 1'b0;
        end
        @(negedge clk); en_in = 1'b0;
        repeat (4) begin
            @(negedge clk);
            fd_any |= frame_done;
        end
        chk("rstmid_no_done", fd_any, 0);
        chk("rstmid_frame_cnt", frame_cnt, 0);
        chk("rstmid_runt_cnt", runt_cnt, 0);
        chk("rstmid_last_id", last_id, 0);
        chk("rstmid_synced", synced, 0);
        send_frame(7, 64, 1'b0, 3);
        chk("rstmid_next_done", fd2, 1);
        chk("rstmid_next_cnt", frame_cnt, 1);
        chk("rstmid_next_last", last_id, 7);

        // Loss pulses of widths 1, 1, 4 are three edges.
        do_clear();
        for (int p = 0; p < 3; p++) begin
            @(negedge clk); loss_in = 1'b1;
            repeat ((p == 2) ? 3 : 0) @(negedge clk);
            @(negedge clk); loss_in = 1'b0;
        end
        @(negedge clk);
        chk("loss_three", loss_cnt, 3);

        // A loss edge coinciding with clear is not counted.
        @(negedge clk); loss_in = 1'b1; clear_stats = 1'b1;
        @(negedge clk); clear_stats = 1'b0;
        @(negedge clk); loss_in = 1'b0;
        @(negedge clk);
        chk("loss_clear_wins", loss_cnt, 0);

        lcnt = 0; prev = 1'b0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            v = ($urandom_range(0, 2) == 0);
            if (v && !prev) lcnt++;
            prev = v; loss_in = v;
        end
        @(negedge clk); loss_in = 1'b0;
        @(negedge clk);
        chk("loss_random", loss_cnt, lcnt);

`ifdef RX_SEQ_CHECKER_FCS_EN
        do_clear();
        send_frame(1, 64, 1'b0, 3);
        send_frame(2, 64, 1'b1, 3);
        chk("fcs_err_cnt", fcs_err_cnt, 1);
        chk("fcs_frame_cnt", frame_cnt, 1);
        chk("fcs_seq_err", se2, 1);
        chk("fcs_last_id", last_id, 1);
        chk("fcs_stale_cnt", stale_cnt, 0);
        send_frame(2, 64, 1'b0, 3);
        chk("fcs_good_after", frame_cnt, 2);
        chk("fcs_good_se", se2, 0);
`else
        send_frame(3, 64, 1'b1, 3);
        chk("fcs_tied_zero", fcs_err_cnt, 0);
`endif

        // Randomized frames with 1..3 idle cycles, checked by the monitor.
        do_clear();
        model_reset();
        evq.delete();
        mon_en = 1'b1;
        for (int f = 0; f < 80; f++) begin
            r   = $urandom_range(0, 9);
            len = $urandom_range(40, 90);
            case (r)
                0, 1, 2, 3, 4: id = m_exp;
                5, 6:          id = (m_exp + $urandom_range(1, 5)) % 65536;
                7:             id = (m_exp + 65536 - $urandom_range(1, 3)) % 65536;
                8:             id = $urandom_range(0, 65535);
                default: begin
                    id  = $urandom_range(0, 65535);
                    len = $urandom_range(5, 35);
                end
            endcase
            send_frame(id, len, ($urandom_range(0, 7) == 0), $urandom_range(1, 3));
        end
        repeat (4) @(negedge clk);
        mon_en = 1'b0;
        chk("rand_events_drained", evq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
